// File: rtl/mux8_arbiter_if.sv
// Bus between the eight requesters and the mux8 arbiter/sequencer.
//
// Handshake: req[i] is a level request that requester i holds high for as
// long as it wants the channel. The arbiter answers with a registered,
// one-hot grant, the mux select sw and valid. Valid=1 means the mux output
// is owned and meaningful in this cycle. The owner releases early by
// raising done for one cycle (only looked at while it owns the channel) or
// by dropping its req bit. timeout pulses for one cycle in the dead cycle
// after the arbiter took the channel away because the hold limit ran out.
interface mux8_arbiter_if;
   logic [7:0] req;
   logic       done;
   logic [2:0] sw;
   logic [7:0] grant;
   logic       valid;
   logic       timeout;

   modport master (
      output req, done,
      input  sw, grant, valid, timeout
   );

   modport slave (
      input  req, done,
      output sw, grant, valid, timeout
   );
endinterface

// File: rtl/mux8_arbiter.sv
// Round-robin arbiter and select sequencer for an 8:1 single-bit mux tree.
// One owner at a time, each grant limited to HOLD_MAX cycles, and exactly
// one dead cycle between owners so the shared output never switches while
// someone holds the grant. HOLD_MAX must lie in 1..15 (4-bit hold counter).
module mux8_arbiter #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   mux8_arbiter_if.slave bus,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(HOLD_MAX - 1);

   state_t     state_q, state_d;
   logic [2:0] sw_q, sw_d;
   logic [7:0] grant_q, grant_d;
   logic       valid_q, valid_d;
   logic       timeout_q, timeout_d;
   logic [2:0] last_q, last_d;
   logic [3:0] cnt_q, cnt_d;

   logic       win_found;
   logic [2:0] win_idx;
   logic [2:0] cand;
   logic       owner_req;
   logic       release_now;

   // Round-robin search: start just after the last winner, so the previous
   // owner (if still requesting) is considered last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = 3'd0;
      cand      = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         cand = last_q + 3'(k);
         if (!win_found && bus.req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // Release conditions for the current owner.
   always_comb begin
      owner_req   = bus.req[sw_q];
      release_now = bus.done || !owner_req || (cnt_q == CNT_LAST);
   end

   // Next-state and registered-output computation.
   always_comb begin
      state_d   = state_q;
      sw_d      = sw_q;
      grant_d   = grant_q;
      valid_d   = valid_q;
      timeout_d = 1'b0;
      last_d    = last_q;
      cnt_d     = cnt_q;
      case (state_q)
         ST_IDLE, ST_GAP: begin
            grant_d = 8'd0;
            valid_d = 1'b0;
            if (win_found) begin
               state_d = ST_BUSY;
               sw_d    = win_idx;
               grant_d = 8'd1 << win_idx;
               valid_d = 1'b1;
               last_d  = win_idx;
               cnt_d   = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_BUSY: begin
            cnt_d = cnt_q + 4'd1;
            if (release_now) begin
               state_d   = ST_GAP;
               grant_d   = 8'd0;
               valid_d   = 1'b0;
               // Only a pure hold-limit release is flagged as a timeout.
               timeout_d = !bus.done && owner_req;
            end
         end
         default: begin
            state_d = ST_IDLE;
            grant_d = 8'd0;
            valid_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset gives index 0 first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         sw_q      <= 3'd0;
         grant_q   <= 8'd0;
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         last_q    <= 3'd7;
         cnt_q     <= 4'd0;
      end else begin
         state_q   <= state_d;
         sw_q      <= sw_d;
         grant_q   <= grant_d;
         valid_q   <= valid_d;
         timeout_q <= timeout_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.sw      = sw_q;
   assign bus.grant   = grant_q;
   assign bus.valid   = valid_q;
   assign bus.timeout = timeout_q;
   assign dbg_state   = state_q;

endmodule

// File: doc/mux8_arbiter.md
# mux8_arbiter

Round-robin arbiter and sequencer for the 8:1 single-bit mux tree. Eight requesters share the mux output. The block decides which requester owns the channel and drives the mux's 3-bit select. It enforces a bounded hold time and inserts one dead cycle between owners so the shared output never switches mid-grant.

## Interface
Parameters:
- HOLD_MAX, 4, maximum consecutive owned cycles per grant; legal range 1..15.

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous, active-low reset.
- Req  in  8  request per input; bit i corresponds to mux data input i (select value i).
- Done  in  1  the current owner releases the channel; sampled only in BUSY.
- SW  out  3  select to the 8:1 mux; registered.
- Grant  out  8  one-hot owner indication; all zeros when no owner; registered.
- Valid  out  1  mux output is owned and meaningful this cycle; registered.
- Timeout  out  1  one-cycle pulse, asserted during the GAP cycle that follows a forced release.

## Operation
- State machine:
  - IDLE: Grant=0, Valid=0.
  - BUSY: one owner.
  - GAP: one dead cycle after a release; Grant=0, Valid=0.
- Round-robin pointer Last (3 bits) holds the most recent winner.
  - Search order: Last+1, Last+2, …, Last+8, all mod 8 (wraps 7→0).
  - The first index with Req set wins.
- IDLE:
  - If Req≠0 at the edge: load SW=winner, Grant=1<<winner, Valid=1, Last=winner, Cnt=0, then enter BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Cnt (4 bits) increments every BUSY cycle.
  - Release at the edge when any of these holds:
    - Done=1.
    - Req[SW]=0.
    - Cnt==HOLD_MAX-1.
  - On release: enter GAP, Grant=0, Valid=0.
  - Timeout=1 in GAP only if the release was due to Cnt alone (Done=0 and Req[SW]=1).
  - Requests from non-owners are ignored while in BUSY.
- GAP:
  - SW holds its previous value.
  - If Req≠0: arbitrate exactly as in IDLE and enter BUSY.
  - Otherwise enter IDLE.
  - A preempted owner still requesting is searched last, because Last points to it.
- SW changes only on the edge that enters BUSY. It holds its value in IDLE and GAP.
- Simultaneous Done and Cnt limit: treated as a normal release, so Timeout=0.
- HOLD_MAX=1: every grant lasts exactly one cycle. Timeout pulses whenever the owner is still requesting with Done=0.

## Timing
- Reset (async assert, sync-safe deassert) forces:
  - State=IDLE, SW=0, Grant=0, Valid=0, Timeout=0.
  - Last=7, so index 0 has first priority.
  - Cnt=0.
- Reset mid-grant: outputs clear immediately, without waiting for a clock edge.
- Grant latency: Req sampled high at edge N (IDLE) → Grant/Valid/SW valid after edge N.
- Grant duration: at most HOLD_MAX cycles of Valid=1.
- Handoff: exactly one GAP cycle (Valid=0) between consecutive owners. Minimum period per grant is 2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then Req=8'b0000_0001 held, Done=0, HOLD_MAX=4:
  - Grant=8'h01, SW=0, Valid=1 for 4 cycles.
  - Then GAP with Timeout=1.
  - Then Grant=8'h01 again; repeats.
- Req=8'hFF held, Done pulsed on the 2nd BUSY cycle of each grant:
  - SW sequence 0,1,2,…,7,0 (wrap).
  - Each grant lasts 2 Valid cycles, separated by 1 GAP; Timeout stays 0.
- Req=8'b1000_0100 with Last=2 (after a grant to 2):
  - Next winner is 7, then 2.
  - Verify no grant goes to a non-requesting index.
- Owner drops Req[SW] on its 1st BUSY cycle:
  - Release next edge, GAP, then IDLE if Req=0. Timeout=0, SW unchanged in IDLE.
- Done=1 on the same edge Cnt reaches HOLD_MAX-1:
  - Release with Timeout=0.
- Assert Resetn=0 asynchronously mid-BUSY with SW=5:
  - Grant=0, Valid=0, SW=0 immediately.
  - After release, with Req=8'hFF, the first winner is 0.
